// File: rtl/ghost_mode_sequencer.sv
// ghost_mode_sequencer: update strobe divider plus the scatter/chase phase
// schedule, frightened timer and eaten-until-home state shared by all ghosts.
// Every state change happens at COMMIT, the clock edge on which `update`
// falls, so the outputs stay steady across both `update` edges.
// Optional feature macro: FRIGHT_FLASH_EN (flash indicator near the end of
// frightened mode). When the macro is undefined, `flash` is tied to 0.
//
// Handshake note: there is no valid/ready traffic here. energizer_eaten and
// ghost_caught are single-cycle pulses captured into sticky pending flags on
// any cycle and consumed at the next COMMIT; ghost_home is a level sampled
// only at COMMIT.
module ghost_mode_sequencer #(
   parameter int UPDATE_DIV    = 6250000,
   parameter int SCATTER_LONG  = 56,
   parameter int SCATTER_SHORT = 40,
   parameter int CHASE_LEN     = 160,
   parameter int FRIGHT_LEN    = 48,
   parameter int FLASH_LEN     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       game_enable,
   input  logic       energizer_eaten,
   input  logic       ghost_caught,
   input  logic       ghost_home,
   output logic       update,
   output logic [3:0] mode,
   output logic       rotate,
   output logic [2:0] phase,
   output logic       flash
);

   localparam int DIV_W = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(UPDATE_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF_M1 = DIV_W'(UPDATE_DIV / 2 - 1);

   localparam logic [15:0] LEN_SCATTER_LONG  = 16'(SCATTER_LONG);
   localparam logic [15:0] LEN_SCATTER_SHORT = 16'(SCATTER_SHORT);
   localparam logic [15:0] LEN_CHASE         = 16'(CHASE_LEN);
   localparam logic [15:0] LEN_FRIGHT        = 16'(FRIGHT_LEN);

   // mode is the FSM state; it is exposed directly on the `mode` port
   localparam logic [3:0] MODE_CHASE   = 4'b1000;
   localparam logic [3:0] MODE_SCATTER = 4'b0100;
   localparam logic [3:0] MODE_FRIGHT  = 4'b0010;
   localparam logic [3:0] MODE_EATEN   = 4'b0001;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             update_q, update_d;
   logic             commit;
   logic [3:0]       mode_q, mode_d;
   logic             rotate_q, rotate_d;
   logic [2:0]       phase_q, phase_d;
   logic [15:0]      phase_timer_q, phase_timer_d;
   logic [15:0]      fright_timer_q, fright_timer_d;
   logic             pend_e_q, pend_e_d;
   logic             pend_c_q, pend_c_d;

   // Length of a scatter/chase phase; phase 7 never reloads so its value is moot
   function automatic logic [15:0] phase_len(input logic [2:0] p);
      case (p)
         3'd0, 3'd2: phase_len = LEN_SCATTER_LONG;
         3'd4, 3'd6: phase_len = LEN_SCATTER_SHORT;
         default:    phase_len = LEN_CHASE;
      endcase
   endfunction

   // Even phases scatter, odd phases (including the final phase 7) chase
   function automatic logic [3:0] phase_mode(input logic [2:0] p);
      phase_mode = p[0] ? MODE_CHASE : MODE_SCATTER;
   endfunction

   // Divider: update rises on the wrap, falls at the half point (COMMIT)
   always_comb begin
      div_cnt_d = div_cnt_q;
      update_d  = update_q;
      commit    = 1'b0;
      if (game_enable) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            update_d  = 1'b1;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
         if (update_q && (div_cnt_q == DIV_HALF_M1)) begin
            update_d = 1'b0;
            commit   = 1'b1;
         end
      end
   end

   // Mode FSM, phase schedule, frightened timer and pending-event capture
   always_comb begin
      mode_d         = mode_q;
      rotate_d       = rotate_q;
      phase_d        = phase_q;
      phase_timer_d  = phase_timer_q;
      fright_timer_d = fright_timer_q;
      pend_e_d       = pend_e_q | energizer_eaten;
      pend_c_d       = pend_c_q | ghost_caught;
      if (commit) begin
         // a pulse landing on the COMMIT cycle itself waits for the next one
         pend_e_d = energizer_eaten;
         pend_c_d = ghost_caught;
         rotate_d = 1'b0;
         case (mode_q)
            MODE_FRIGHT: begin
               if (pend_c_q) begin
                  mode_d         = MODE_EATEN;
                  fright_timer_d = '0;
               end else if (pend_e_q) begin
                  fright_timer_d = LEN_FRIGHT;
                  rotate_d       = 1'b1;
               end else if (fright_timer_q == 16'd1) begin
                  mode_d         = phase_mode(phase_q);
                  fright_timer_d = '0;
               end else begin
                  fright_timer_d = fright_timer_q - 16'd1;
               end
            end
            MODE_EATEN: begin
               if (ghost_home) begin
                  mode_d = phase_mode(phase_q);
               end
            end
            default: begin
               // scatter or chase; the phase timer is frozen while frightened
               if (pend_e_q) begin
                  mode_d         = MODE_FRIGHT;
                  fright_timer_d = LEN_FRIGHT;
                  rotate_d       = 1'b1;
               end else if (phase_q != 3'd7) begin
                  if (phase_timer_q == 16'd1) begin
                     phase_d       = phase_q + 3'd1;
                     phase_timer_d = phase_len(phase_q + 3'd1);
                     mode_d        = phase_mode(phase_q + 3'd1);
                     rotate_d      = 1'b1;
                  end else begin
                     phase_timer_d = phase_timer_q - 16'd1;
                  end
               end
            end
         endcase
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q      <= '0;
         update_q       <= 1'b0;
         mode_q         <= MODE_SCATTER;
         rotate_q       <= 1'b0;
         phase_q        <= 3'd0;
         phase_timer_q  <= LEN_SCATTER_LONG;
         fright_timer_q <= '0;
         pend_e_q       <= 1'b0;
         pend_c_q       <= 1'b0;
      end else begin
         div_cnt_q      <= div_cnt_d;
         update_q       <= update_d;
         mode_q         <= mode_d;
         rotate_q       <= rotate_d;
         phase_q        <= phase_d;
         phase_timer_q  <= phase_timer_d;
         fright_timer_q <= fright_timer_d;
         pend_e_q       <= pend_e_d;
         pend_c_q       <= pend_c_d;
      end
   end

`ifdef FRIGHT_FLASH_EN
   localparam logic [15:0] LEN_FLASH = 16'(FLASH_LEN);

   logic flash_q, flash_d;

   // Flash toggles only on a plain frightened countdown inside the flash window
   always_comb begin
      flash_d = flash_q;
      if (commit) begin
         if ((mode_q == MODE_FRIGHT) && !pend_c_q && !pend_e_q &&
             (fright_timer_q != 16'd1) && (fright_timer_q <= LEN_FLASH)) begin
            flash_d = ~flash_q;
         end else begin
            flash_d = 1'b0;
         end
      end
   end

   // Flash register
   always_ff @(posedge clk) begin
      if (reset) begin
         flash_q <= 1'b0;
      end else begin
         flash_q <= flash_d;
      end
   end

   assign flash = flash_q;
`else
   assign flash = 1'b0;
`endif

   assign update = update_q;
   assign mode   = mode_q;
   assign rotate = rotate_q;
   assign phase  = phase_q;

endmodule
